// File: rtl/gate_ops_pkg.sv
// Shared opcode, reserved-range and FSM state definitions for the gate
// arbiter and its combinational gate unit.
package gate_ops_pkg;

  localparam logic [2:0] OP_BUF  = 3'd0;
  localparam logic [2:0] OP_NOT  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;

  // Opcodes from OP_RSV_LO up to the top of the 3-bit space are reserved.
  localparam logic [2:0] OP_RSV_LO = 3'd6;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  function automatic logic is_reserved(input logic [2:0] opcode);
    return opcode >= OP_RSV_LO;
  endfunction

endpackage

// File: rtl/gate_unit.sv
// Purely combinational W-bit bitwise evaluator shared by all requesters.
module gate_unit
  import gate_ops_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         err
);

  always_comb begin
    y   = '0;
    err = is_reserved(op);
    case (op)
      OP_BUF:  y = a;
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one gate unit among NREQ requesters; one grant
// per two cycles, with a registered, tagged response one cycle after the grant.
module gate_op_arbiter
  import gate_ops_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] op,
  input  logic [W*NREQ-1:0] a,
  input  logic [W*NREQ-1:0] b,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  output logic [2:0]        rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [2:0]      op_q, op_d;
  logic [2:0]      id_q, id_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [2:0]      rsp_id_q, rsp_id_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  logic            found;
  int              win_i;
  int              idx;
  logic [W-1:0]    gu_y;
  logic            gu_err;

  // Search starts at ptr and wraps, so the first hit is the round-robin winner.
  always_comb begin
    found = 1'b0;
    win_i = 0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win_i = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_BUSY;
      S_BUSY:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = '0;
    ptr_d       = ptr_q;
    op_d        = op_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d[win_i] = 1'b1;
          ptr_d        = PW'((win_i + 1) % NREQ);
          op_d         = op[3*win_i +: 3];
          a_d          = a[W*win_i +: W];
          b_d          = b[W*win_i +: W];
          id_d         = 3'(win_i);
        end
      end
      S_BUSY: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_data_d  = gu_y;
        rsp_err_d   = gu_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      op_q        <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      op_q        <= op_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  gate_unit #(.W(W)) u_gate_unit (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .y   (gu_y),
    .err (gu_err)
  );

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule
